nested_index_counter: RTL
=========================

Name: nested_index_counter

Overview:
- Two-level, parametrised successor to the flat index counter.
- Generates (outer, inner) index pairs over a runtime-programmable 2-D range, e.g. neuron x weight traversal for a multiplexed layer.
- Pairs leave on a valid/ready stream. The block adds a start handshake, inclusive runtime limits, last flags, a done pulse, continuous/one-shot mode and abort.

Parameters:
- INNER_WIDTH, 10, width of inner index and inner_max.
- OUTER_WIDTH, 10, width of outer index and outer_max.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
- start  input  1  pulse; begins a sweep when idle.
- abort  input  1  synchronous; terminates a sweep.
- continuous  input  1  mode select, sampled on accepted start; 1 = wrap forever, 0 = one sweep.
- inner_max  input  INNER_WIDTH  last inner index (inclusive), sampled on accepted start.
- outer_max  input  OUTER_WIDTH  last outer index (inclusive), sampled on accepted start.
- busy  output  1  high in RUN.
- inner_idx  output  INNER_WIDTH  current inner index.
- outer_idx  output  OUTER_WIDTH  current outer index.
- idx_valid  output  1  index pair valid.
- idx_ready  input  1  consumer accepts pair.
- inner_last  output  1  inner_idx == latched inner_max (qualified by idx_valid).
- outer_last  output  1  outer_idx == latched outer_max and inner_last.
- done  output  1  one-cycle pulse after final transfer of a one-shot sweep.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0.
  - Latched limits and mode cleared to 0.
- States are IDLE, RUN, DONE.
- IDLE:
  - idx_valid=0; indices held at 0.
  - start=1 latches inner_max, outer_max and continuous, then moves to RUN.
  - Latency: start in cycle N gives idx_valid=1 with (0,0) in cycle N+1.
- RUN:
  - idx_valid=1, busy=1.
  - A transfer is idx_valid & idx_ready.
  - On transfer:
    - If inner < inner_max: inner+1.
    - Otherwise inner<=0, then:
      - if outer < outer_max: outer+1;
      - otherwise outer<=0, and if continuous the block stays in RUN, else it goes to DONE.
  - No transfer: indices and flags held stable. The pair must not change while idx_valid & !idx_ready.
  - start is ignored in RUN and DONE.
- DONE (one cycle):
  - done=1, idx_valid=0, busy=0, indices 0.
  - Next state is IDLE unconditionally; a start in this cycle is ignored.
- Abort:
  - abort=1 in RUN or DONE returns to IDLE next cycle with indices 0 and no done pulse.
  - abort has priority over a same-cycle transfer; that transfer is not counted.
  - abort in IDLE has no effect, and has priority over start.
- Limits are inclusive:
  - inner_max=0 or outer_max=0 is legal and means a single index on that axis.
  - (0,0) gives exactly one transfer per sweep.
- Flags:
  - inner_last and outer_last are combinational from the registered indices and latched limits.
  - Both are 0 when idx_valid=0.
  - A one-shot sweep produces (inner_max+1)*(outer_max+1) transfers.
- Input changes after start do not affect an active sweep.
- Counter arithmetic is unsigned, fixed width, and never overflows, because the index resets at its max.
- Reset mid-sweep forces IDLE immediately (asynchronous) with outputs 0; the first start after release behaves as from power-up.

Test Plan:
- Basic one-shot:
  - Stimulus: start with inner_max=2, outer_max=1, continuous=0, idx_ready held 1.
  - Response: pairs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on 6 consecutive cycles beginning 1 cycle after start.
  - inner_last on inner=2; outer_last only on (1,2).
  - done pulse the cycle after (1,2); busy falls.
- Backpressure:
  - Stimulus: same limits, idx_ready toggled randomly.
  - Response: pair held stable while ready=0; the same 6-pair sequence is observed in order with no duplicates or skips.
- Degenerate range:
  - Stimulus: inner_max=0, outer_max=0.
  - Response: exactly one transfer (0,0) with inner_last=outer_last=1, then done.
- Continuous wrap:
  - Stimulus: inner_max=1, outer_max=1, continuous=1, run 10 transfers.
  - Response: the sequence (0,0),(0,1),(1,0),(1,1) repeats; done never asserts; busy stays 1.
- Abort and ignored start:
  - Stimulus: mid-sweep, start=1 with new limits, then abort coincident with a transfer.
  - Response: start has no effect; IDLE next cycle; no done; the next start sweeps from (0,0) with newly sampled limits.
- Async reset:
  - Stimulus: rst=0 asserted between clock edges during RUN.
  - Response: idx_valid, busy and indices go to 0 immediately without a clock edge; after release the block stays in IDLE until start.

Source files
------------

// File: rtl/nested_index_counter.sv
// Two-level (outer, inner) index generator over runtime-inclusive limits.
// Pairs leave on a valid/ready stream; one-shot sweeps end with a done pulse.
module nested_index_counter #(
    parameter int INNER_WIDTH = 10,
    parameter int OUTER_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [INNER_WIDTH-1:0] inner_max,
    input  logic [OUTER_WIDTH-1:0] outer_max,
    output logic                   busy,
    output logic [INNER_WIDTH-1:0] inner_idx,
    output logic [OUTER_WIDTH-1:0] outer_idx,
    output logic                   idx_valid,
    input  logic                   idx_ready,
    output logic                   inner_last,
    output logic                   outer_last,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [INNER_WIDTH-1:0] INNER_ONE = 1;
    localparam logic [OUTER_WIDTH-1:0] OUTER_ONE = 1;

    state_t                 state_q, state_d;
    logic [INNER_WIDTH-1:0] inner_q, inner_d;
    logic [OUTER_WIDTH-1:0] outer_q, outer_d;
    logic [INNER_WIDTH-1:0] inner_max_q, inner_max_d;
    logic [OUTER_WIDTH-1:0] outer_max_q, outer_max_d;
    logic                   cont_q, cont_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            inner_q     <= '0;
            outer_q     <= '0;
            inner_max_q <= '0;
            outer_max_q <= '0;
            cont_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            inner_q     <= inner_d;
            outer_q     <= outer_d;
            inner_max_q <= inner_max_d;
            outer_max_q <= outer_max_d;
            cont_q      <= cont_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        inner_d     = inner_q;
        outer_d     = outer_q;
        inner_max_d = inner_max_q;
        outer_max_d = outer_max_q;
        cont_d      = cont_q;
        unique case (state_q)
            S_IDLE: begin
                inner_d = '0;
                outer_d = '0;
                if (!abort && start) begin
                    state_d     = S_RUN;
                    inner_max_d = inner_max;
                    outer_max_d = outer_max;
                    cont_d      = continuous;
                end
            end
            S_RUN: begin
                // abort wins over a same-cycle transfer
                if (abort) begin
                    state_d = S_IDLE;
                    inner_d = '0;
                    outer_d = '0;
                end else if (idx_ready) begin
                    if (inner_q < inner_max_q) begin
                        inner_d = inner_q + INNER_ONE;
                    end else begin
                        inner_d = '0;
                        if (outer_q < outer_max_q) begin
                            outer_d = outer_q + OUTER_ONE;
                        end else begin
                            outer_d = '0;
                            if (!cont_q) state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                inner_d = '0;
                outer_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                inner_d = '0;
                outer_d = '0;
            end
        endcase
    end

    assign busy       = (state_q == S_RUN);
    assign idx_valid  = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign inner_idx  = inner_q;
    assign outer_idx  = outer_q;
    assign inner_last = idx_valid && (inner_q == inner_max_q);
    assign outer_last = inner_last && (outer_q == outer_max_q);

endmodule
